serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
Parametrised multi-cycle two's-complement adder/subtractor. It processes an N-bit operand pair DIGIT bits per clock through a chain of 1-bit full-adder slices. A registered carry links successive digits. Subtraction is performed as A + ~B + 1. Inputs and outputs use valid/ready handshakes, and the block reports carry/no-borrow, signed overflow and zero flags. It is the area-scalable arithmetic unit for datapaths that cannot afford a full-width ripple adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be at least 2.
DIGIT, 1, bits processed per clock; 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0 (elaboration-time check).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair and mode are valid
in_ready  output  1  unit can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B; sampled with operands
out_valid  output  1  result and flags are valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum/difference, modulo 2^WIDTH
cout  output  1  carry out of MSB; for subtract 1 = no borrow (A >= B unsigned)
ovf  output  1  signed overflow
zero  output  1  result == 0
busy  output  1  state != IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - in_ready = 1, out_valid = 0, busy = 0
  - result = 0, cout = 0, ovf = 0, zero = 0
  - internal shift registers, carry and digit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch op_a; latch op_b, inverted if sub = 1; carry register = sub; digit counter = 0; go to RUN.
- RUN:
  - Each cycle, feed the low DIGIT bits of the A/B shift registers and the carry register through DIGIT chained full-adder slices.
  - Shift the DIGIT sum bits into result from the MSB end. Shift A and B right by DIGIT. Register the chain carry-out. Increment the counter.
  - On the edge that processes digit WIDTH/DIGIT-1, capture final cout and ovf and go to DONE.
  - ovf = carry into MSB XOR carry out of MSB. This is captured from the internal slice chain in the final digit.
  - in_ready = 0 throughout RUN; in_valid is ignored.
- DONE:
  - out_valid = 1. result, cout, ovf and zero are held stable until out_valid && out_ready.
  - zero is derived combinationally from the held result.
  - On the handshake, go to IDLE. in_ready is 0 in DONE, so there is no same-cycle input acceptance.
- Latency: out_valid rises WIDTH/DIGIT rising edges after the acceptance edge. Throughput is one operation per WIDTH/DIGIT+2 cycles with out_ready held at 1.
- DIGIT == WIDTH degenerates to a single RUN cycle. Latency is then 1.
- Back-pressure: out_ready low in DONE holds all outputs indefinitely. Operand changes on input ports while busy have no effect.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values. The partial result is discarded; no out_valid pulse follows.
- Width rules: arithmetic is modulo 2^WIDTH with no saturation. cout and ovf are independent flags.

Decomposition:
- Shared package serial_addsub_pkg:
  - state enum (IDLE, RUN, DONE)
  - function computing counter width, $clog2(WIDTH/DIGIT) with minimum 1
  - parameter-legality constants
- One sub-module: addsub_bit_slice, a 1-bit full adder (a, b, cin -> sum, cout). It is instantiated DIGIT times in a generate loop to form the per-cycle ripple chain.
- Operand inversion and carry-in injection stay in the parent.

Test Plan:
1. WIDTH=8, DIGIT=1: A=0x7F, B=0x01, sub=0 -> result=0x80, cout=0, ovf=1, zero=0; out_valid exactly 8 edges after acceptance.
2. WIDTH=8, DIGIT=1: A=0x05, B=0x05, sub=1 -> result=0x00, cout=1, ovf=0, zero=1. Then A=0x00, B=0x01, sub=1 -> result=0xFF, cout=0, ovf=0.
3. WIDTH=8, DIGIT=4: A=0x80, B=0x01, sub=1 -> result=0x7F, cout=1, ovf=1; latency 2 edges. Then A=0xFF, B=0x01, sub=0 -> result=0x00, cout=1, zero=1, ovf=0.
4. Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, result/flags unchanged, in_ready=0. An in_valid pulse during that time is not accepted.
5. Reset mid-RUN: drop rst_n on cycle 3 of an 8-cycle op -> all outputs go to reset values asynchronously. After release, in_ready=1, and no spurious out_valid occurs.
6. Random regression: 10k random operand/mode pairs, each parameter set (8/1, 8/4, 16/16, 32/8). Compare against a behavioural reference, with random out_ready stalls and back-to-back in_valid.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MIN_DIGIT = 1;

  // Digit counter width; a single-digit operation still needs one bit.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = $clog2(width / digit);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic bit params_legal(input int width, input int digit);
    return (width >= MIN_WIDTH) && (digit >= MIN_DIGIT) &&
           (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_unit_if.sv
// Operand/result handshake bundle; master drives operands, slave is the arithmetic unit.
interface serial_addsub_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero, busy
  );
endinterface

// File: rtl/addsub_bit_slice.sv
// One-bit full adder; chained DIGIT times to form the per-cycle ripple.
module addsub_bit_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement add/subtract: WIDTH bits in WIDTH/DIGIT cycles,
// subtraction done as A + ~B + 1 with the +1 injected through the carry register.
module serial_addsub_unit
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_addsub_unit_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
      $error("serial_addsub_unit: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_res_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [DIGIT:0]   w_chain;
  logic [DIGIT-1:0] w_sum;
  logic             w_last;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  assign w_chain[0] = r_carry;
  assign w_last     = (r_cnt == LAST);
  assign w_accept   = (r_state == IDLE) && bus.in_valid;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
      addsub_bit_slice u_slice (
        .i_a    (r_a[gi]),
        .i_b    (r_b[gi]),
        .i_cin  (w_chain[gi]),
        .o_sum  (w_sum[gi]),
        .o_cout (w_chain[gi+1])
      );
    end

    // New sum digit enters at the MSB end so the result is aligned after the last digit.
    if (DIGIT == WIDTH) begin : g_res_full
      assign w_res_next = w_sum;
    end else begin : g_res_shift
      assign w_res_next = {w_sum, r_result[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == DONE);
    w_busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
      r_carry <= bus.sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_result <= w_res_next;
      r_carry  <= w_chain[DIGIT];
      r_cnt    <= r_cnt + CW'(1);
      // In the final digit the top slice is the MSB, so its carry-in/out give overflow.
      if (w_last) begin
        r_cout <= w_chain[DIGIT];
        r_ovf  <= w_chain[DIGIT] ^ w_chain[DIGIT-1];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = w_out_valid && (r_result == '0);

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Four parameterisations run side by side against an arithmetic reference model.
module tb_serial_addsub_unit;

  localparam int NL = 4;

  function automatic int lane_w(input int l);
    case (l)
      0: return 8;
      1: return 8;
      2: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int lane_d(input int l);
    case (l)
      0: return 1;
      1: return 4;
      2: return 16;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0]       in_valid_d, sub_d, out_ready_d;
  logic [NL-1:0][31:0] opa_d, opb_d;
  logic [NL-1:0]       in_ready_o, out_valid_o, cout_o, ovf_o, zero_o, busy_o;
  logic [NL-1:0][31:0] res_o;

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      localparam int W = lane_w(gi);
      localparam int D = lane_d(gi);
      serial_addsub_unit_if #(.WIDTH(W)) u_bus ();
      assign u_bus.in_valid  = in_valid_d[gi];
      assign u_bus.op_a      = opa_d[gi][W-1:0];
      assign u_bus.op_b      = opb_d[gi][W-1:0];
      assign u_bus.sub       = sub_d[gi];
      assign u_bus.out_ready = out_ready_d[gi];
      assign in_ready_o[gi]  = u_bus.in_ready;
      assign out_valid_o[gi] = u_bus.out_valid;
      assign cout_o[gi]      = u_bus.cout;
      assign ovf_o[gi]       = u_bus.ovf;
      assign zero_o[gi]      = u_bus.zero;
      assign busy_o[gi]      = u_bus.busy;
      assign res_o[gi]       = 32'(u_bus.result);
      serial_addsub_unit #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
      );
    end
  endgenerate

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected {cout, ovf, zero, result[31:0]} from plain integer arithmetic.
  function automatic logic [34:0] model(input int w, input logic [31:0] ain,
                                        input logic [31:0] bin, input logic s);
    longint a, b, sa, sb, full, tr, lim;
    logic [31:0] r;
    logic c, v;
    lim = longint'(1) << w;
    a = longint'({32'd0, ain}) & (lim - 1);
    b = longint'({32'd0, bin}) & (lim - 1);
    sa = (a >= lim / 2) ? a - lim : a;
    sb = (b >= lim / 2) ? b - lim : b;
    if (s) begin
      full = a - b; c = (a >= b); tr = sa - sb;
    end else begin
      full = a + b; c = (full >= lim); tr = sa + sb;
    end
    r = 32'(full & (lim - 1));
    v = (tr >= lim / 2) || (tr < -(lim / 2));
    return {c, v, (r == 32'd0), r};
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m, v;
    m = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h1 << (w - 1);
      3: v = (32'h1 << (w - 1)) - 32'd1;
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  task automatic chk(input string nm, input int l, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s lane%0d cyc=%0d got=%h want=%h", nm, l, cyc, got, want);
    end
  endtask

  // Directed literal expectations, set by the driver for the op in flight.
  logic [NL-1:0]       lit_on = '0;
  logic [34:0]         lit_exp [NL];
  bit                  fin_req = 0;
  bit                  fin_done = 0;

  // Reference state: one outstanding operation per lane.
  bit          pend [NL];
  int          acc  [NL];
  int          ndone[NL];
  logic [34:0] exp_v[NL];
  logic [31:0] sa_v [NL];
  logic [31:0] sb_v [NL];
  logic        ss_v [NL];

  initial begin
    int L;
    bit ov_exp, acc_now, hs_now;
    logic [63:0] got;
    for (int l = 0; l < NL; l++) begin
      pend[l] = 0; acc[l] = 0; ndone[l] = 0; exp_v[l] = '0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        L = lane_w(l) / lane_d(l);
        if (!rst_n) begin
          pend[l] = 0;
          chk("reset_state", l,
              64'({out_valid_o[l], in_ready_o[l], busy_o[l], cout_o[l], ovf_o[l], zero_o[l], res_o[l]}),
              64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}));
        end else begin
          ov_exp = pend[l] && (cyc >= acc[l] + L);
          chk("handshake", l, 64'({in_ready_o[l], busy_o[l], out_valid_o[l]}),
              64'({!pend[l], pend[l], ov_exp}));
          if (ov_exp) begin
            got = 64'({cout_o[l], ovf_o[l], zero_o[l], res_o[l]});
            chk("result", l, got, 64'(exp_v[l]));
            if (lit_on[l]) chk("directed", l, got, 64'(lit_exp[l]));
          end
          acc_now = !pend[l] && in_valid_d[l];
          hs_now  = ov_exp && out_ready_d[l];
          if (hs_now) begin
            pend[l] = 0;
            ndone[l]++;
            $display("lane%0d W=%0d D=%0d a=%h b=%h sub=%0d -> res=%h cout=%0d ovf=%0d zero=%0d",
                     l, lane_w(l), lane_d(l), sa_v[l], sb_v[l], ss_v[l],
                     res_o[l], cout_o[l], ovf_o[l], zero_o[l]);
          end
          if (acc_now) begin
            pend[l]  = 1;
            acc[l]   = cyc + 1;
            exp_v[l] = model(lane_w(l), opa_d[l], opb_d[l], sub_d[l]);
            sa_v[l]  = opa_d[l];
            sb_v[l]  = opb_d[l];
            ss_v[l]  = sub_d[l];
          end
        end
      end
      if (fin_req && !fin_done) begin
        for (int l = 0; l < NL; l++) chk("activity", l, 64'(ndone[l] > 20), 64'd1);
        fin_done = 1;
      end
    end
  end

  task automatic start_op(input int l, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [34:0] want);
    int t;
    t = 0;
    while (!in_ready_o[l]) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        $display("FAIL start_timeout lane%0d in_ready=%0d required=1", l, in_ready_o[l]);
        $fatal(1);
      end
    end
    opa_d[l] = a; opb_d[l] = b; sub_d[l] = s;
    lit_exp[l] = want; lit_on[l] = 1'b1;
    in_valid_d[l] = 1'b1;
    @(posedge clk); #1;
    in_valid_d[l] = 1'b0;
  endtask

  task automatic wait_valid(input int l);
    int t;
    t = 0;
    while (!out_valid_o[l]) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        $display("FAIL valid_timeout lane%0d out_valid=%0d required=1", l, out_valid_o[l]);
        $fatal(1);
      end
    end
  endtask

  task automatic wait_clear(input int l);
    int t;
    t = 0;
    while (out_valid_o[l]) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        $display("FAIL clear_timeout lane%0d out_valid=%0d required=0", l, out_valid_o[l]);
        $fatal(1);
      end
    end
    lit_on[l] = 1'b0;
  endtask

  task automatic run_op(input int l, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [34:0] want);
    start_op(l, a, b, s, want);
    wait_valid(l);
    wait_clear(l);
  endtask

  initial begin
    in_valid_d = '0; sub_d = '0; out_ready_d = '1;
    opa_d = '0; opb_d = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // {cout, ovf, zero, result}
    run_op(0, 32'h7F, 32'h01, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80});
    run_op(0, 32'h05, 32'h05, 1'b1, {1'b1, 1'b0, 1'b1, 32'h00});
    run_op(0, 32'h00, 32'h01, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFF});
    run_op(1, 32'h80, 32'h01, 1'b1, {1'b1, 1'b1, 1'b0, 32'h7F});
    run_op(1, 32'hFF, 32'h01, 1'b0, {1'b1, 1'b0, 1'b1, 32'h00});
    run_op(2, 32'h8000, 32'h8000, 1'b0, {1'b1, 1'b1, 1'b1, 32'h0000});
    run_op(3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b0, 1'b1, 1'b0, 32'h8000_0000});

    // Stall in DONE; an input pulse meanwhile must be ignored.
    out_ready_d[0] = 1'b0;
    start_op(0, 32'h12, 32'h34, 1'b0, {1'b0, 1'b0, 1'b0, 32'h46});
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      in_valid_d[0] = (i == 3);
      opa_d[0] = 32'hAA; opb_d[0] = 32'h55;
      @(posedge clk); #1;
    end
    in_valid_d[0] = 1'b0;
    out_ready_d[0] = 1'b1;
    wait_clear(0);

    // Reset partway through an 8-digit operation.
    start_op(0, 32'h3C, 32'h0F, 1'b1, {1'b0, 1'b0, 1'b0, 32'h2D});
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lit_on[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    for (int c = 0; c < 6000; c++) begin
      for (int l = 0; l < NL; l++) begin
        in_valid_d[l]  = ($urandom_range(0, 3) != 0);
        opa_d[l]       = pick(lane_w(l));
        opb_d[l]       = pick(lane_w(l));
        sub_d[l]       = 1'($urandom_range(0, 1));
        out_ready_d[l] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    in_valid_d = '0;
    out_ready_d = '1;
    repeat (80) @(posedge clk);
    #1 fin_req = 1;
    repeat (3) @(posedge clk);
    if (!fin_done) begin
      n_cmp++; n_bad++;
      $display("FAIL final_check fin_done=%0d required=1", fin_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
